// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI-lite register file.
// Holds the response encoding, FSM state types and the byte-lane merge function.
package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  // Widest supported bus; narrower instances zero-extend into the helper.
  localparam int unsigned MaxDataWidth = 64;
  localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

  typedef enum logic [1:0] {
    WIdle,
    WHaveA,
    WHaveD,
    WResp
  } wr_state_t;

  typedef enum logic {
    RIdle,
    RData
  } rd_state_t;

  function automatic logic [MaxDataWidth-1:0] strb_merge(
    input logic [MaxDataWidth-1:0] old_data,
    input logic [MaxDataWidth-1:0] new_data,
    input logic [MaxStrbWidth-1:0] strb
  );
    logic [MaxDataWidth-1:0] res;
    res = old_data;
    for (int k = 0; k < MaxStrbWidth; k++) begin
      if (strb[k]) begin
        res[k*8 +: 8] = new_data[k*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// Combinational byte-lane merge of write data into an existing register value.
// One instance serves every register; the write FSM muxes the target in.
module axil_strb_merge
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  logic [MaxDataWidth-1:0] merged_full;

  assign merged_full = strb_merge(MaxDataWidth'(old_i), MaxDataWidth'(data_i),
                                  MaxStrbWidth'(strb_i));
  assign merged_o    = merged_full[DATA_WIDTH-1:0];

  if (DATA_WIDTH < MaxDataWidth) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^merged_full[MaxDataWidth-1:DATA_WIDTH];
  end

endmodule

// File: rtl/axil_regfile.sv
// AXI-lite slave register file: RW control registers with byte strobes, RO status
// registers, out-of-order AW/W acceptance, SLVERR on decode/RO errors, write pulses.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int unsigned                    DATA_WIDTH = 32,
  parameter int unsigned                    ADDR_WIDTH = 12,
  parameter int unsigned                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_i,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned IdxWidth  = ADDR_WIDTH - OffWidth;

  function automatic logic [NUM_REGS*DATA_WIDTH-1:0] reset_image();
    logic [NUM_REGS*DATA_WIDTH-1:0] img;
    img = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) begin
        img[i*DATA_WIDTH +: DATA_WIDTH] = RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return img;
  endfunction

  localparam logic [NUM_REGS*DATA_WIDTH-1:0] ResetImage = reset_image();

  // One-hot register select; all-zero means the index is past the last register.
  function automatic logic [NUM_REGS-1:0] decode(input logic [IdxWidth-1:0] idx);
    logic [NUM_REGS-1:0] sel;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (idx == IdxWidth'(i));
    end
    return sel;
  endfunction

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic [IdxWidth-1:0]            aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0]          w_data_q, w_data_d;
  logic [StrbWidth-1:0]           w_strb_q, w_strb_d;
  resp_t                          bresp_q, bresp_d;
  resp_t                          rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            wr_pulse_q, wr_pulse_d;

  logic                  commit;
  logic [IdxWidth-1:0]   c_idx;
  logic [DATA_WIDTH-1:0] c_data, c_old, c_merged;
  logic [StrbWidth-1:0]  c_strb;
  logic [NUM_REGS-1:0]   c_sel, c_wr, r_sel;

  logic unused_addr;
  assign unused_addr = ^{awaddr[OffWidth-1:0], araddr[OffWidth-1:0]};

  // Write channel: AW and W may arrive together or in either order.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_idx_d   = aw_idx_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    commit     = 1'b0;
    c_idx      = aw_idx_q;
    c_data     = w_data_q;
    c_strb     = w_strb_q;
    unique case (wr_state_q)
      WIdle: begin
        awready = 1'b1;
        wready  = 1'b1;
        c_idx   = awaddr[ADDR_WIDTH-1:OffWidth];
        c_data  = wdata;
        c_strb  = wstrb;
        if (awvalid && wvalid) begin
          commit     = 1'b1;
          wr_state_d = WResp;
        end else if (awvalid) begin
          aw_idx_d   = awaddr[ADDR_WIDTH-1:OffWidth];
          wr_state_d = WHaveA;
        end else if (wvalid) begin
          w_data_d   = wdata;
          w_strb_d   = wstrb;
          wr_state_d = WHaveD;
        end
      end
      WHaveA: begin
        wready = 1'b1;
        c_data = wdata;
        c_strb = wstrb;
        if (wvalid) begin
          commit     = 1'b1;
          wr_state_d = WResp;
        end
      end
      WHaveD: begin
        awready = 1'b1;
        c_idx   = awaddr[ADDR_WIDTH-1:OffWidth];
        if (awvalid) begin
          commit     = 1'b1;
          wr_state_d = WResp;
        end
      end
      WResp: begin
        bvalid = 1'b1;
        if (bready) begin
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  assign c_sel = decode(c_idx);
  assign c_wr  = c_sel & ~RO_MASK;

  always_comb begin
    c_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (c_sel[i]) begin
        c_old = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  axil_strb_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_strb_merge (
    .old_i   (c_old),
    .data_i  (c_data),
    .strb_i  (c_strb),
    .merged_o(c_merged)
  );

  // Decode and RO errors fall out naturally: c_wr is all-zero for both.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    bresp_d    = bresp_q;
    if (commit) begin
      wr_pulse_d = c_wr;
      bresp_d    = (|c_wr) ? RESP_OKAY : RESP_SLVERR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (c_wr[i]) begin
          regs_d[i*DATA_WIDTH +: DATA_WIDTH] = c_merged;
        end
      end
    end
  end

  assign r_sel = decode(araddr[ADDR_WIDTH-1:OffWidth]);

  // Read channel: data is captured from regs_q, so a same-edge write is not seen.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    arready    = 1'b0;
    rvalid     = 1'b0;
    unique case (rd_state_q)
      RIdle: begin
        arready = 1'b1;
        if (arvalid) begin
          rd_state_d = RData;
          rdata_d    = '0;
          rresp_d    = (|r_sel) ? RESP_OKAY : RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (r_sel[i]) begin
              rdata_d = RO_MASK[i] ? reg_i[i*DATA_WIDTH +: DATA_WIDTH]
                                   : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
      RData: begin
        rvalid = 1'b1;
        if (rready) begin
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WIdle;
      rd_state_q <= RIdle;
      aw_idx_q   <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      regs_q     <= ResetImage;
      wr_pulse_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_idx_q   <= aw_idx_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign reg_o    = regs_q;
  assign wr_pulse = wr_pulse_q;
  assign bresp    = bresp_q;
  assign rresp    = rresp_q;
  assign rdata    = rdata_q;

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
- Parametrised AXI-lite slave register file, the next-generation successor to the bare Axi Slave modport.
- Terminates one AXI-lite port and exposes NUM_REGS control registers (read/write) and status registers (read-only) to core logic.
- Adds behaviour the plain interface lacks: byte strobes, AW/W accepted in either order, decode and read-only errors via 2-bit resp, per-register write pulses.
- Sits between the host interconnect and accelerator control/status logic.

Parameters:
- DATA_WIDTH, 32, register and bus data width; 32 or 64.
- ADDR_WIDTH, 12, byte address width used for decode.
- NUM_REGS, 16, number of word registers; 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RO_MASK, '0, NUM_REGS-bit mask; bit i set = register i read-only (returns reg_i slice).
- RESET_VAL, '0, NUM_REGS*DATA_WIDTH flat reset image for RW registers.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- awaddr  in  ADDR_WIDTH  write byte address
- awvalid  in  1 / awready  out  1  write-address handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wvalid  in  1 / wready  out  1  write-data handshake
- bvalid  out  1 / bready  in  1  write-response handshake
- bresp  out  2  00 OKAY, 10 SLVERR
- araddr  in  ADDR_WIDTH  read byte address
- arvalid  in  1 / arready  out  1  read-address handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid  out  1 / rready  in  1  read-data handshake
- reg_o  out  NUM_REGS*DATA_WIDTH  flat RW register contents; register i at [i*DATA_WIDTH +: DATA_WIDTH]
- reg_i  in  NUM_REGS*DATA_WIDTH  status inputs for RO registers
- wr_pulse  out  NUM_REGS  one-cycle strobe on a committed write to register i

Behaviour:
- Reset (areset high at a clock edge):
  - reg_o = RESET_VAL, all RO slices 0.
  - awready = wready = arready = 1.
  - bvalid = rvalid = 0; bresp = rresp = 00; rdata = 0; wr_pulse = 0.
  - Any in-flight transaction is dropped, no response is issued, and both FSMs return to idle.
- Decode:
  - idx = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits are ignored.
  - idx >= NUM_REGS is a decode error.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - W_IDLE: awready = wready = 1.
    - Both handshake in the same cycle -> commit, go to W_RESP.
    - AW only -> latch address, go to W_HAVE_A.
    - W only -> latch data and strobes, go to W_HAVE_D.
  - W_HAVE_A: awready = 0, wready = 1. On W handshake -> commit, go to W_RESP.
  - W_HAVE_D: wready = 0, awready = 1. On AW handshake -> commit, go to W_RESP.
  - Commit happens on the clock edge that completes the pair:
    - Valid RW idx: byte k of reg i is updated when wstrb[k] = 1; wr_pulse[i] = 1 for the next cycle only; bresp = 00.
    - Decode error: no update, no pulse, bresp = 10.
    - RO register: no update, no pulse, bresp = 10.
    - Valid RW idx with wstrb = 0: no data change, wr_pulse still asserted, bresp = 00.
  - W_RESP: awready = wready = 0; bvalid = 1, held stable until bready; on the bvalid&bready edge go to W_IDLE.
  - Latency: a same-cycle AW+W handshake at edge N gives bvalid and the reg_o update visible after edge N, i.e. 1 cycle.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready = 1. On AR handshake, rdata/rresp are registered at that edge:
    - RW register: reg_o slice.
    - RO register: reg_i slice.
    - Decode error: rdata = 0, rresp = 10.
    - Then rvalid = 1 and go to R_DATA.
  - R_DATA: arready = 0; rdata, rresp and rvalid held stable until rready; on the handshake edge go to R_IDLE.
  - Latency: 1 cycle from AR handshake to rvalid.
- Concurrency:
  - Read and write channels are independent and may both be in flight.
  - A read handshaking on the same edge as a write commit to the same register returns the pre-write value.
- Errors never stall the bus; every accepted transaction gets exactly one response.

Decomposition:
- Package axil_pkg:
  - resp_t (2-bit) with RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - wr_state_t and rd_state_t enums.
  - Function strb_merge(old, data, strb).
- One sub-module, axil_strb_merge: combinational byte-lane merge, shared by all registers.
- Write and read FSMs stay in axil_regfile.

Test Plan:
- Reset, then AW+W same cycle: addr 0x004, wdata 0xDEADBEEF, wstrb 0xF -> bvalid the next cycle with bresp 00; reg_o[1] = 0xDEADBEEF; wr_pulse = 0x0002 for one cycle.
- W first, AW three cycles later to addr 0x008 -> wready drops after the W handshake; commit on the AW handshake; one bresp 00.
- With reg1 = 0xDEADBEEF, write wstrb 0x3, wdata 0x00001234 to addr 0x004 -> reg_o[1] = 0xDEAD1234.
- Write to addr 0x040 with NUM_REGS = 16, then read the same address -> bresp 10; no register changes; rdata 0, rresp 10.
- RO_MASK bit 2 set, reg_i[2] = 0xCAFE0001: read addr 0x008 -> rdata 0xCAFE0001, rresp 00; write to 0x008 -> bresp 10, no pulse.
- bready and rready held low for 5 cycles -> bvalid/rvalid and data held stable; no new AW, W or AR accepted. Then assert areset mid-R_DATA -> rvalid = 0, arready = 1 the next cycle; reg_o = RESET_VAL.
